// File: rtl/regfile_4r2w_pkg.sv
// Shared widths, polarities and types for the 4-read / 2-write register file.
// These are the common core definitions used by every regfile source file.
package regfile_4r2w_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    localparam logic RstEnable   = 1'b1;
    localparam logic WriteEnable = 1'b1;
    localparam logic ReadEnable  = 1'b1;

    localparam logic [RegBus-1:0] ZeroWord = '0;

    typedef logic [RegBus-1:0]     word_t;
    typedef logic [RegAddrBus-1:0] addr_t;

    // One commit slot, as seen by the read ports for write-to-read bypass.
    typedef struct packed {
        logic  we;
        addr_t addr;
        word_t data;
    } wr_port_t;

endpackage

// File: rtl/regfile_rd_port.sv
// Single combinational read port: zero-register, read-enable and reset gating.
// Optional same-cycle write-to-read bypass selected by REGFILE_BYPASS_EN.
module regfile_rd_port
    import regfile_4r2w_pkg::*;
(
    input  logic     i_rst,
    input  logic     i_re,
    input  addr_t    i_raddr,
    input  word_t    i_stored,
    input  wr_port_t i_wr1,
    input  wr_port_t i_wr2,
    output word_t    o_rdata
);

    always_comb begin
        // NOTE: default assignment first so every path drives o_rdata and no latch is inferred.
        o_rdata = ZeroWord;
        if (i_rst != RstEnable && i_re == ReadEnable && i_raddr != '0) begin
`ifdef REGFILE_BYPASS_EN
            // Slot 2 is the younger instruction, so it takes precedence.
            if (i_wr2.we == WriteEnable && i_wr2.addr == i_raddr) begin
                o_rdata = i_wr2.data;
            end else if (i_wr1.we == WriteEnable && i_wr1.addr == i_raddr) begin
                o_rdata = i_wr1.data;
            end else begin
                o_rdata = i_stored;
            end
`else
            o_rdata = i_stored;
`endif
        end
    end

`ifndef REGFILE_BYPASS_EN
    // Write ports feed only the bypass path; fold them so they are consumed.
    logic w_unused;
    assign w_unused = ^{i_wr1, i_wr2};
`endif

endmodule

// File: rtl/regfile_4r2w.sv
// Dual-issue register file: 31 GPRs plus HI/LO, four read ports, two commit slots.
// Define REGFILE_BYPASS_EN to forward same-cycle writes onto the read ports.
module regfile_4r2w
    import regfile_4r2w_pkg::*;
(
    input  logic  clk,
    input  logic  rst,

    input  logic  we1,
    input  addr_t waddr1,
    input  word_t wdata1,
    input  logic  we2,
    input  addr_t waddr2,
    input  word_t wdata2,

    input  logic  re1,
    input  addr_t raddr1,
    output word_t rdata1,
    input  logic  re2,
    input  addr_t raddr2,
    output word_t rdata2,
    input  logic  re3,
    input  addr_t raddr3,
    output word_t rdata3,
    input  logic  re4,
    input  addr_t raddr4,
    output word_t rdata4,

    input  logic  whilo,
    input  word_t hi_i,
    input  word_t lo_i,
    output word_t hi_o,
    output word_t lo_o
);

    word_t r_gpr [2**RegAddrBus];
    word_t r_hi;
    word_t r_lo;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            // NOTE: the array is cleared on reset because reads after reset must return 0.
            for (int i = 0; i < 2**RegAddrBus; i++) begin
                r_gpr[i] <= ZeroWord;
            end
            r_hi <= ZeroWord;
            r_lo <= ZeroWord;
        end else begin
            // NOTE: non-blocking updates; on an address collision the later slot-2 assignment wins.
            if (we1 == WriteEnable && waddr1 != '0) begin
                r_gpr[waddr1] <= wdata1;
            end
            if (we2 == WriteEnable && waddr2 != '0) begin
                r_gpr[waddr2] <= wdata2;
            end
            if (whilo == WriteEnable) begin
                r_hi <= hi_i;
                r_lo <= lo_i;
            end
        end
    end

    assign hi_o = (rst == RstEnable) ? ZeroWord : r_hi;
    assign lo_o = (rst == RstEnable) ? ZeroWord : r_lo;

    wr_port_t w_wr1;
    wr_port_t w_wr2;
    assign w_wr1 = '{we: we1, addr: waddr1, data: wdata1};
    assign w_wr2 = '{we: we2, addr: waddr2, data: wdata2};

    logic  w_re    [4];
    addr_t w_raddr [4];
    word_t w_rdata [4];

    assign w_re    = '{re1, re2, re3, re4};
    assign w_raddr = '{raddr1, raddr2, raddr3, raddr4};

    for (genvar g = 0; g < 4; g++) begin : g_rd
        regfile_rd_port u_rd_port (
            .i_rst    (rst),
            .i_re     (w_re[g]),
            .i_raddr  (w_raddr[g]),
            .i_stored (r_gpr[w_raddr[g]]),
            .i_wr1    (w_wr1),
            .i_wr2    (w_wr2),
            .o_rdata  (w_rdata[g])
        );
    end

    assign rdata1 = w_rdata[0];
    assign rdata2 = w_rdata[1];
    assign rdata3 = w_rdata[2];
    assign rdata4 = w_rdata[3];

endmodule

// File: tb/tb_regfile_4r2w.sv
// Randomized bench for regfile_4r2w against an array-based reference model.
// Build with REGFILE_BYPASS_EN defined to check the bypass configuration.
module tb_regfile_4r2w;

    logic        clk = 1'b0;
    logic        rst;
    logic        we1, we2;
    logic [4:0]  waddr1, waddr2;
    logic [31:0] wdata1, wdata2;
    logic        re1, re2, re3, re4;
    logic [4:0]  raddr1, raddr2, raddr3, raddr4;
    logic [31:0] rdata1, rdata2, rdata3, rdata4;
    logic        whilo;
    logic [31:0] hi_i, lo_i, hi_o, lo_o;

    always #5 clk = ~clk;

    regfile_4r2w dut (
        .clk    (clk),
        .rst    (rst),
        .we1    (we1),
        .waddr1 (waddr1),
        .wdata1 (wdata1),
        .we2    (we2),
        .waddr2 (waddr2),
        .wdata2 (wdata2),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .re3    (re3),
        .raddr3 (raddr3),
        .rdata3 (rdata3),
        .re4    (re4),
        .raddr4 (raddr4),
        .rdata4 (rdata4),
        .whilo  (whilo),
        .hi_i   (hi_i),
        .lo_i   (lo_i),
        .hi_o   (hi_o),
        .lo_o   (lo_o)
    );

    // Reference state: architectural register contents after the last edge.
    logic [31:0] m_gpr [32];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
        if (rst || !re || a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (we2 && waddr2 == a) return wdata2;
        if (we1 && waddr1 == a) return wdata1;
`endif
        return m_gpr[a];
    endfunction

    task automatic check_outputs();
        #1;
        check("rdata1", rdata1, exp_rd(re1, raddr1));
        check("rdata2", rdata2, exp_rd(re2, raddr2));
        check("rdata3", rdata3, exp_rd(re3, raddr3));
        check("rdata4", rdata4, exp_rd(re4, raddr4));
        check("hi_o", hi_o, rst ? 32'h0 : m_hi);
        check("lo_o", lo_o, rst ? 32'h0 : m_lo);
    endtask

    // Check combinational outputs, then apply one clock edge to DUT and model.
    task automatic tick();
        check_outputs();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
            m_hi = 32'h0;
            m_lo = 32'h0;
        end else begin
            if (we1 && waddr1 != 5'd0) m_gpr[waddr1] = wdata1;
            if (we2 && waddr2 != 5'd0) m_gpr[waddr2] = wdata2;
            if (whilo) begin
                m_hi = hi_i;
                m_lo = lo_i;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        we1 = 0; we2 = 0; whilo = 0;
        re1 = 0; re2 = 0; re3 = 0; re4 = 0;
        waddr1 = 0; waddr2 = 0; wdata1 = 0; wdata2 = 0;
        raddr1 = 0; raddr2 = 0; raddr3 = 0; raddr4 = 0;
        hi_i = 0; lo_i = 0;
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
        m_hi = 32'h0;
        m_lo = 32'h0;
        idle();
        rst = 1;
        tick();
        tick();
        rst = 0;

        // Reset after a write: r5 must read back 0.
        we1 = 1; waddr1 = 5; wdata1 = 32'hDEADBEEF;
        tick();
        idle();
        re1 = 1; raddr1 = 5;
        #1 check("r5_written", rdata1, 32'hDEADBEEF);
        rst = 1;
        #1 check("r5_in_rst", rdata1, 32'h0);
        tick();
        rst = 0;
        #1 check("r5_after_rst", rdata1, 32'h0);
        tick();

        // Dual write on one edge.
        idle();
        we1 = 1; waddr1 = 3; wdata1 = 32'h11111111;
        we2 = 1; waddr2 = 4; wdata2 = 32'h22222222;
        tick();
        idle();
        re1 = 1; raddr1 = 3; re3 = 1; raddr3 = 4;
        #1 check("dual_r3", rdata1, 32'h11111111);
        check("dual_r4", rdata3, 32'h22222222);
        tick();

        // Collision: slot 2 wins.
        idle();
        we1 = 1; waddr1 = 7; wdata1 = 32'hAAAA0000;
        we2 = 1; waddr2 = 7; wdata2 = 32'h0000BBBB;
        tick();
        idle();
        re2 = 1; raddr2 = 7;
        #1 check("collide_r7", rdata2, 32'h0000BBBB);
        tick();

        // Zero register and disabled read port.
        idle();
        we1 = 1; waddr1 = 0; wdata1 = 32'hFFFFFFFF;
        tick();
        idle();
        re1 = 1; re2 = 1; re3 = 1; re4 = 1;
        #1 check("r0_p1", rdata1, 32'h0);
        check("r0_p2", rdata2, 32'h0);
        check("r0_p3", rdata3, 32'h0);
        check("r0_p4", rdata4, 32'h0);
        re2 = 0; raddr2 = 7;
        #1 check("re2_off", rdata2, 32'h0);
        tick();

        // Same-cycle read of a register being written.
        idle();
        we1 = 1; waddr1 = 9; wdata1 = 32'h12345678;
        re4 = 1; raddr4 = 9;
`ifdef REGFILE_BYPASS_EN
        #1 check("bypass_r9", rdata4, 32'h12345678);
`else
        #1 check("nobypass_r9", rdata4, 32'h0);
`endif
        tick();

        // HI/LO write and hold.
        idle();
        whilo = 1; hi_i = 32'h1; lo_i = 32'h2;
        tick();
        idle();
        hi_i = 32'hCAFE0000; lo_i = 32'h0000F00D;
        #1 check("hi_set", hi_o, 32'h1);
        check("lo_set", lo_o, 32'h2);
        tick();
        check("hi_hold", hi_o, 32'h1);
        check("lo_hold", lo_o, 32'h2);

        // Randomized traffic with dense address reuse.
        for (int n = 0; n < 600; n++) begin
            rst    = ($urandom_range(0, 49) == 0);
            we1    = 1'($urandom);
            we2    = 1'($urandom);
            waddr1 = rand_addr();
            waddr2 = ($urandom_range(0, 3) == 0) ? waddr1 : rand_addr();
            wdata1 = $urandom;
            wdata2 = $urandom;
            re1    = ($urandom_range(0, 7) != 0);
            re2    = ($urandom_range(0, 7) != 0);
            re3    = ($urandom_range(0, 7) != 0);
            re4    = ($urandom_range(0, 7) != 0);
            raddr1 = rand_addr();
            raddr2 = rand_addr();
            raddr3 = ($urandom_range(0, 3) == 0) ? waddr2 : rand_addr();
            raddr4 = ($urandom_range(0, 3) == 0) ? waddr1 : rand_addr();
            whilo  = ($urandom_range(0, 3) == 0);
            hi_i   = $urandom;
            lo_i   = $urandom;
            tick();
        end
        rst = 0;
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
